// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
// Feeds a wide operand pair one nibble per cycle into an external 4-bit CLA
// whose A/B inputs are registered and whose Cin is combinational. It collects
// S/Cout per nibble and returns the assembled sum and carry-out over a
// valid/ready handshake.
// Optional build macro: CLA_SEQ_OVF_EN adds out_ovf (two's-complement overflow).
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic [3:0]           cla_a,
    output logic [3:0]           cla_b,
    output logic                 cla_cin,
    input  logic [3:0]           cla_s,
    input  logic                 cla_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam int IW = $clog2(NIBBLES);
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST_FEED = CW'(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NIBBLES-1:0][3:0] r_op_a;
    logic [NIBBLES-1:0][3:0] r_op_b;
    logic [NIBBLES-1:0][3:0] r_sum;
    logic                    r_carry;
    logic                    r_cout;
    logic [CW-1:0]           r_feed_idx;
    logic [IW-1:0]           r_cap_idx;
`ifdef CLA_SEQ_OVF_EN
    logic                    r_ovf;
`endif

    logic                    w_accept;
    logic                    w_feeding;
    logic                    w_capturing;
    logic                    w_last_capture;
    logic [IW-1:0]           w_feed_nib;

    // The CLA registers A/B, so a nibble fed while feed_idx=k is evaluated
    // (and its result captured) one edge later, when feed_idx=k+1.
    assign w_accept       = (r_state == S_IDLE) && in_valid;
    assign w_feeding      = (r_state == S_RUN) && (r_feed_idx < LAST_FEED);
    assign w_capturing    = (r_state == S_RUN) && (r_feed_idx != '0);
    assign w_last_capture = (r_state == S_RUN) && (r_feed_idx == LAST_FEED);
    assign w_feed_nib     = r_feed_idx[IW-1:0];

    // Carry register drives CLA Cin directly: in_cin for nibble 0, then the
    // captured Cout of nibble k-1 while nibble k is being evaluated.
    assign cla_cin  = r_carry;
    assign out_sum  = r_sum;
    assign out_cout = r_cout;
`ifdef CLA_SEQ_OVF_EN
    assign out_ovf  = r_ovf;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_feed_idx == LAST_FEED) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake and CLA operand outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cla_a     = '0;
        cla_b     = '0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                if (w_feeding) begin
                    cla_a = r_op_a[w_feed_nib];
                    cla_b = r_op_b[w_feed_nib];
                end
            end
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, nibble indices, per-nibble capture and final result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_feed_idx <= '0;
            r_cap_idx  <= '0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op_a     <= in_a;
                r_op_b     <= in_b;
                r_carry    <= in_cin;
                r_feed_idx <= '0;
                r_cap_idx  <= '0;
            end
            if (r_state == S_RUN) begin
                r_feed_idx <= r_feed_idx + CW'(1);
            end
            // No capture on the first RUN edge: the CLA holds no valid result yet.
            if (w_capturing) begin
                r_sum[r_cap_idx] <= cla_s;
                r_carry          <= cla_cout;
                r_cap_idx        <= r_cap_idx + IW'(1);
            end
            if (w_last_capture) begin
                r_cout <= cla_cout;
`ifdef CLA_SEQ_OVF_EN
                r_ovf  <= (r_op_a[NIBBLES-1][3] == r_op_b[NIBBLES-1][3]) &&
                          (cla_s[3] != r_op_a[NIBBLES-1][3]);
`endif
            end
        end
    end

endmodule
